ddr3_osc_power_sequencer: RTL

- Sequences DDR3 power-up timing (RESET# hold, CKE wait) from the ECP5 internal oscillator clock, before the fabric PLL or controller clocks are trusted.
- Waits for PLL lock, then drives ddr_reset_n and ddr_cke to the memory.
- Hands off to the DDR3 init engine with a start/done handshake and reports overall readiness.
- Sits between the OSCG primitive and the controller's init FSM.

---
 rtl/ddr3_osc_power_sequencer_if.sv | 37 +++
 rtl/ddr3_osc_power_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_osc_power_sequencer_if.sv
// ddr3_osc_power_sequencer_if
// Signal bundle between the oscillator-clocked DDR3 power sequencer, the PLL,
// the DDR3 memory pins and the controller's init engine.
// Optional feature macro: DDR3_SEQ_INIT_TIMEOUT_EN (adds init_timeout).
interface ddr3_osc_power_sequencer_if;
    logic       pll_lock;     // PLL lock, asynchronous to the oscillator clock
    logic       init_done;    // init engine finished MRS/ZQ
    logic       ddr_reset_n;  // DDR3 RESET#
    logic       ddr_cke;      // DDR3 CKE
    logic       init_start;   // level request to the init engine
    logic       ready;        // memory usable
    logic       fault;        // sticky lock-loss indication
    logic [2:0] state_o;      // debug view of the sequencer state
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
    logic       init_timeout; // sticky: init engine never answered
`endif

`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
    modport master (
        input  pll_lock, init_done,
        output ddr_reset_n, ddr_cke, init_start, ready, fault, state_o, init_timeout
    );
    modport slave (
        output pll_lock, init_done,
        input  ddr_reset_n, ddr_cke, init_start, ready, fault, state_o, init_timeout
    );
`else
    modport master (
        input  pll_lock, init_done,
        output ddr_reset_n, ddr_cke, init_start, ready, fault, state_o
    );
    modport slave (
        output pll_lock, init_done,
        input  ddr_reset_n, ddr_cke, init_start, ready, fault, state_o
    );
`endif
endinterface

// File: rtl/ddr3_osc_power_sequencer.sv
// ddr3_osc_power_sequencer
// Runs from the ECP5 OSCG clock. Waits for a stable PLL lock, holds DDR3
// RESET# low, waits before raising CKE, then hands over to the init engine
// with a start/done handshake. Losing lock once sequencing has begun parks
// the memory pins low and raises a sticky fault.
// Optional feature macro: DDR3_SEQ_INIT_TIMEOUT_EN (init handshake timeout).
module ddr3_osc_power_sequencer #(
    parameter int unsigned LOCK_STABLE_CYC    = 16,
    parameter int unsigned T_RESET_CYC        = 485,
    parameter int unsigned T_CKE_CYC          = 1211,
    parameter int unsigned CNT_W              = 12
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
   ,parameter int unsigned T_INIT_TIMEOUT_CYC = 4000
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    ddr3_osc_power_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK  = 3'd0,
        S_RESET_HOLD = 3'd1,
        S_CKE_WAIT   = 3'd2,
        S_INIT_REQ   = 3'd3,
        S_RUN        = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    typedef struct packed {
        logic ddr_reset_n;
        logic ddr_cke;
        logic init_start;
        logic ready;
    } pins_t;

    localparam logic [CNT_W-1:0] LD_LOCK  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_CYC - 1);
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(T_INIT_TIMEOUT_CYC - 1);
`endif

    // Pin levels belonging to each state; unused encodings fall to all-low.
    function automatic pins_t pins_for(input state_t s);
        pins_t p;
        p = '0;
        case (s)
            S_CKE_WAIT: p.ddr_reset_n = 1'b1;
            S_INIT_REQ: begin
                p.ddr_reset_n = 1'b1;
                p.ddr_cke     = 1'b1;
                p.init_start  = 1'b1;
            end
            S_RUN: begin
                p.ddr_reset_n = 1'b1;
                p.ddr_cke     = 1'b1;
                p.ready       = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

    logic [1:0]       r_rst_sync;
    logic             w_rst;
    logic             r_lock_meta;
    logic             r_lock_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_expire;
    pins_t            r_pins;
    logic             r_fault;
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
    logic             w_timeout_set;
    logic             r_init_timeout;
`endif

    // Reset synchroniser: assert immediately, release two clk edges later.
    // NOTE: rst reaches every flop asynchronously, but its release is retimed
    // to clk so no flop sees the deassertion inside its recovery window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_sync <= 2'b11;
        else     r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    assign w_rst = r_rst_sync[1];

    // Double-flop synchroniser for the asynchronous PLL lock.
    // NOTE: clocked state uses <= so both stages sample the pre-edge values;
    // with = the two stages would collapse into one.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_expire = (r_cnt == '0);

    // Next-state and counter decisions; lock loss outranks every other event.
    // NOTE: every signal gets its default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_expire ? r_cnt : r_cnt - CNT_W'(1);
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
        w_timeout_set = 1'b0;
`endif
        case (r_state)
            S_WAIT_LOCK: begin
                if (!r_lock_s) begin
                    w_cnt_nxt = LD_LOCK;
                end else if (w_expire) begin
                    w_state_nxt = S_RESET_HOLD;
                    w_cnt_nxt   = LD_RESET;
                end
            end
            S_RESET_HOLD: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_FAULT;
                end else if (w_expire) begin
                    w_state_nxt = S_CKE_WAIT;
                    w_cnt_nxt   = LD_CKE;
                end
            end
            S_CKE_WAIT: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_FAULT;
                end else if (w_expire) begin
                    w_state_nxt = S_INIT_REQ;
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
                    w_cnt_nxt   = LD_INIT;
`endif
                end
            end
            S_INIT_REQ: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_FAULT;
                end else if (bus.init_done) begin
                    w_state_nxt = S_RUN;
`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
                end else if (w_expire) begin
                    w_state_nxt   = S_FAULT;
                    w_timeout_set = 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (!r_lock_s) w_state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = LD_LOCK;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = LD_LOCK;
            end
        endcase
    end

    // State, counter and registered (glitch-free) memory pins.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= LD_LOCK;
            r_pins  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pins  <= pins_for(w_state_nxt);
            r_fault <= r_fault | (w_state_nxt == S_FAULT);
        end
    end

`ifdef DDR3_SEQ_INIT_TIMEOUT_EN
    // Sticky record that the init engine never answered in time.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_init_timeout <= 1'b0;
        else       r_init_timeout <= r_init_timeout | w_timeout_set;
    end

    assign bus.init_timeout = r_init_timeout;
`endif

    assign bus.ddr_reset_n = r_pins.ddr_reset_n;
    assign bus.ddr_cke     = r_pins.ddr_cke;
    assign bus.init_start  = r_pins.init_start;
    assign bus.ready       = r_pins.ready;
    assign bus.fault       = r_fault;
    assign bus.state_o     = r_state;

endmodule
